// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the parametrised scratch RAM.
//   state_t          clear-sequencer states (CLEAR sweeps INIT_VAL, IDLE serves ports)
//   RDW_READ_FIRST   same-address read+write returns the old word (latency 1)
//   RDW_WRITE_FIRST  same-address read+write returns the incoming write data (latency 1)
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_core.sv
// ram_core: storage array with one synchronous write port and one asynchronous read port.
//   clk      in  clock, writes on posedge
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out read data, combinational from i_raddr
// The array has no reset; contents persist across rst.
module ram_core #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_param_clr.sv
// ram_param_clr: parametrised single-port scratch RAM with a post-reset clear sweep.
//   clk        in  single clock, all state on posedge
//   rst        in  asynchronous active-high reset
//   we         in  write enable (ignored while busy)
//   re         in  read request, qualifies dbo_valid (ignored while busy)
//   ab         in  word address shared by read and write
//   dbi        in  write data
//   dbo        out read data (combinational or registered per READ_LATENCY)
//   dbo_valid  out dbo carries data for an accepted read
//   busy       out clear sweep in progress
module ram_param_clr
  import ram_pkg::*;
#(
  parameter int unsigned       DATA_W         = 4,
  parameter int unsigned       ADDR_W         = 4,
  parameter int unsigned       READ_LATENCY   = 0,
  parameter int unsigned       RDW_MODE       = 0,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VAL       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] ab,
  input  logic [DATA_W-1:0] dbi,
  output logic [DATA_W-1:0] dbo,
  output logic              dbo_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

  state_t            r_state;
  state_t            w_state_d;
  logic [ADDR_W-1:0] r_clr_addr;

  logic              w_port_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Clear FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Clear FSM: next state; leaves CLEAR on the edge that writes the last word
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      CLEAR:   if (r_clr_addr == LAST_ADDR) w_state_d = IDLE;
      IDLE:    w_state_d = IDLE;
      default: w_state_d = RESET_STATE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    busy = 1'b0;
    unique case (r_state)
      CLEAR:   busy = 1'b1;
      IDLE:    busy = 1'b0;
      default: busy = 1'b0;
    endcase
  end

  // Sweep pointer; wraps to 0 as the sweep finishes, so a later sweep starts clean
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  assign w_port_en = ~busy;

  // Write-port mux: the sweep owns the array while busy
  assign w_mem_we    = busy | (we & w_port_en);
  assign w_mem_waddr = busy ? r_clr_addr : ab;
  assign w_mem_wdata = busy ? INIT_VAL : dbi;

  ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_waddr(w_mem_waddr),
    .i_wdata(w_mem_wdata),
    .i_raddr(ab),
    .o_rdata(w_rdata)
  );

  if (READ_LATENCY == 0) begin : g_lat0
    assign dbo       = w_rdata;
    assign dbo_valid = re & w_port_en;
  end else begin : g_lat1
    logic [DATA_W-1:0] r_dbo;
    logic              r_dbo_valid;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_rd_word;

    assign w_rd_fire = re & w_port_en;
    // Read and write share ab, so any accepted write this cycle hits the read address
    assign w_rd_word = ((RDW_MODE == RDW_WRITE_FIRST) && we) ? dbi : w_rdata;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dbo       <= '0;
        r_dbo_valid <= 1'b0;
      end else begin
        r_dbo_valid <= w_rd_fire;
        if (w_rd_fire) begin
          r_dbo <= w_rd_word;
        end
      end
    end

    assign dbo       = r_dbo;
    assign dbo_valid = r_dbo_valid;
  end

endmodule

// File: tb/tb_ram_param_clr.sv
// Scoreboard bench: three RAM configurations share one stimulus stream.
//   dut 0: latency 1, write-first, clear sweep, INIT_VAL=A
//   dut 1: latency 1, read-first,  clear sweep, INIT_VAL=A
//   dut 2: latency 0, no clear sweep
module tb_ram_param_clr;

  typedef struct packed {
    int       cyc;
    logic [3:0] data;
    logic     known;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [3:0] ab  = '0;
  logic [3:0] dbi = '0;

  logic [3:0] dbo  [3];
  logic       v    [3];
  logic       busy [3];

  int         lat_c  [3] = '{1, 1, 0};
  int         rdw_c  [3] = '{1, 0, 0};
  int         clr_c  [3] = '{1, 1, 0};
  logic [3:0] init_c [3] = '{4'hA, 4'hA, 4'h0};

  // Reference model state
  logic [3:0] m_mem      [3][16];
  bit         m_known    [3][16];
  int         m_busy_left[3];
  bit         exp_busy   [3];
  logic [3:0] hold       [3] = '{4'h0, 4'h0, 4'h0};
  ent_t       sbq        [3][$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ram_param_clr #(
    .DATA_W(4), .ADDR_W(4), .READ_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_VAL(4'hA)
  ) u_l1_wf (
    .clk(clk), .rst(rst), .we(we), .re(re), .ab(ab), .dbi(dbi),
    .dbo(dbo[0]), .dbo_valid(v[0]), .busy(busy[0])
  );

  ram_param_clr #(
    .DATA_W(4), .ADDR_W(4), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_VAL(4'hA)
  ) u_l1_rf (
    .clk(clk), .rst(rst), .we(we), .re(re), .ab(ab), .dbi(dbi),
    .dbo(dbo[1]), .dbo_valid(v[1]), .busy(busy[1])
  );

  ram_param_clr #(
    .DATA_W(4), .ADDR_W(4), .READ_LATENCY(0), .RDW_MODE(0), .CLEAR_ON_RESET(0), .INIT_VAL(4'h0)
  ) u_l0 (
    .clk(clk), .rst(rst), .we(we), .re(re), .ab(ab), .dbi(dbi),
    .dbo(dbo[2]), .dbo_valid(v[2]), .busy(busy[2])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: actual %0h required %0h", name, d, cyc, act, exp);
    end
  endtask

  // Monitor: checks busy every cycle and pops the scoreboard whenever a DUT presents data
  always @(negedge clk) begin
    ent_t e;
    for (int d = 0; d < 3; d++) begin
      chk("busy", d, 32'(busy[d]), 32'(exp_busy[d]));
      if (v[d] === 1'b1) begin
        if (sbq[d].size() == 0) begin
          chk("unexpected_valid", d, 1, 0);
        end else begin
          e = sbq[d].pop_front();
          chk("valid_cycle", d, cyc, e.cyc);
          if (e.known) chk("rdata", d, 32'(dbo[d]), 32'(e.data));
          hold[d] = e.data;
        end
      end else begin
        if (sbq[d].size() != 0 && sbq[d][0].cyc <= cyc) begin
          e = sbq[d].pop_front();
          chk("missing_valid", d, 0, 1);
        end
        if (lat_c[d] == 1) chk("dbo_hold", d, 32'(dbo[d]), 32'(hold[d]));
      end
    end
  end

  // Drive one cycle of stimulus, predict responses, then advance the model past the edge
  task automatic step(bit w, bit r, logic [3:0] a, logic [3:0] di);
    we  = w;
    re  = r;
    ab  = a;
    dbi = di;
    for (int d = 0; d < 3; d++) begin
      if (r && m_busy_left[d] == 0) begin
        ent_t e;
        e.cyc = cyc + lat_c[d];
        if (lat_c[d] == 1 && rdw_c[d] == 1 && w) begin
          e.data  = di;
          e.known = 1'b1;
        end else begin
          e.data  = m_mem[d][a];
          e.known = m_known[d][a];
        end
        sbq[d].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (m_busy_left[d] > 0) begin
        m_busy_left[d]--;
        if (m_busy_left[d] == 0) begin
          for (int i = 0; i < 16; i++) begin
            m_mem[d][i]   = init_c[d];
            m_known[d][i] = 1'b1;
          end
        end
      end else if (w) begin
        m_mem[d][a]   = di;
        m_known[d][a] = 1'b1;
      end
      exp_busy[d] = (m_busy_left[d] > 0);
    end
  endtask

  task automatic rand_step();
    step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  // Asserts rst immediately (asynchronously w.r.t. the edge) and holds it n cycles
  task automatic do_reset(int n);
    we  = 1'b0;
    re  = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sbq[d].delete();
      hold[d]        = 4'h0;
      m_busy_left[d] = 0;
      exp_busy[d]    = (clr_c[d] != 0);
    end
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) m_busy_left[d] = (clr_c[d] != 0) ? 16 : 0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 4'(a), 4'h0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      exp_busy[d]    = (clr_c[d] != 0);
      m_busy_left[d] = 0;
      for (int i = 0; i < 16; i++) m_known[d][i] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset(2);

    // Sweep window: a write to 15 on clear cycle 5 must be dropped by sweeping duts
    for (int k = 0; k < 16; k++) begin
      if (k == 5) step(1'b1, 1'b1, 4'd15, 4'h3);
      else        rand_step();
    end
    read_all();

    // Write then read back, followed by idle cycles with dbo held
    step(1'b1, 1'b0, 4'd3, 4'h5);
    step(1'b0, 1'b1, 4'd3, 4'h0);
    step(1'b0, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b0, 4'd0, 4'h0);

    // Same-address read during write
    step(1'b1, 1'b0, 4'd7, 4'h2);
    step(1'b1, 1'b1, 4'd7, 4'h9);
    step(1'b0, 1'b1, 4'd7, 4'h0);
    step(1'b0, 1'b0, 4'd0, 4'h0);

    repeat (300) rand_step();

    // Reset right after an accepted latency-1 read: dbo/dbo_valid clear at once
    step(1'b0, 1'b1, 4'd7, 4'h0);
    do_reset(1);

    // Reset mid-sweep at address 8, then a full sweep
    repeat (8) rand_step();
    do_reset(2);
    repeat (16) rand_step();
    read_all();
    repeat (20) rand_step();
    step(1'b0, 1'b0, 4'd0, 4'h0);
    step(1'b0, 1'b0, 4'd0, 4'h0);

    for (int d = 0; d < 3; d++) chk("leftover_expected", d, sbq[d].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
